// File: rtl/jenc_pkg.sv
// Shared definitions for the JPEG encoder front end.
//   MAX_WIDTH  : widest stripe in pixels (multiple of 8)
//   LB_DEPTH   : line-buffer depth in 64-bit words (8 rows x MAX_WIDTH/8)
//   LB_ADDR_W  : line-buffer word address width
//   LB_DATA_W  : line-buffer word width (8 pixels x 8 bits)
//   rd_state_e : block reader FSM states
//   beat_t     : one block-row beat with its position tags (67 bits)
package jenc_pkg;

    localparam int MAX_WIDTH = 1440;
    localparam int LB_DEPTH  = 1440;
    localparam int LB_ADDR_W = $clog2(LB_DEPTH);
    localparam int LB_DATA_W = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } rd_state_e;

    typedef struct packed {
        logic [LB_DATA_W-1:0] data;  // byte 0 = leftmost pixel
        logic                 sob;   // row 0 of a block
        logic                 eob;   // row 7 of a block
        logic                 last;  // row 7 of the last block of the stripe
    } beat_t;

endpackage

// File: rtl/jenc_skid_fifo2.sv
// Two-entry valid/ready FIFO carrying block-row beats.
//   clk, resetn : clock, asynchronous active-low reset
//   in_valid    : push in_beat this cycle (caller guarantees space)
//   in_beat     : beat to store
//   out_valid   : head entry present
//   out_ready   : consumer takes the head this cycle
//   out_beat    : head entry, held stable until taken
//   count       : occupancy 0..2
// A push and a pop in the same cycle are allowed even when full.
module jenc_skid_fifo2
    import jenc_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    input  beat_t      in_beat,
    output logic       out_valid,
    input  logic       out_ready,
    output beat_t      out_beat,
    output logic [1:0] count
);

    beat_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;
    logic  pop;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign out_beat  = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: this storage is reset on purpose -- the head entry drives
            // blk_data_o directly, which must read zero out of reset. Larger
            // memories would normally be left unreset.
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (in_valid) begin
                mem[wr_ptr] <= in_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, in_valid} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/line_buffer_block_reader.sv
// Reads an 8-row stripe out of the line buffer in 8x8 block order and
// streams one 64-bit block row per beat towards the DCT.
//   clk, resetn     : clock, asynchronous active-low reset
//   stripe_valid_i  : writer has filled the 8 rows of a stripe (level)
//   width_i         : stripe width in pixels, sampled on acceptance
//   stripe_done_o   : one-cycle pulse, buffer may be rewritten
//   rd_en_o/rd_addr_o/rd_data_i : line-buffer read port, 1-cycle latency
//   blk_valid_o/blk_ready_i     : output handshake
//   blk_data_o      : one block row, byte 0 = leftmost pixel
//   blk_sob_o/blk_eob_o/blk_last_o : row 0 / row 7 / final row of stripe
// Buffer word address = row*WPL + bx with WPL = width/8.
module line_buffer_block_reader
    import jenc_pkg::*;
#(
    parameter int MAX_WIDTH = jenc_pkg::MAX_WIDTH,
    parameter int ADDR_W    = jenc_pkg::LB_ADDR_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 stripe_valid_i,
    input  logic [10:0]          width_i,
    output logic                 stripe_done_o,
    output logic                 rd_en_o,
    output logic [ADDR_W-1:0]    rd_addr_o,
    input  logic [LB_DATA_W-1:0] rd_data_i,
    output logic                 blk_valid_o,
    input  logic                 blk_ready_i,
    output logic [LB_DATA_W-1:0] blk_data_o,
    output logic                 blk_sob_o,
    output logic                 blk_eob_o,
    output logic                 blk_last_o
);

    localparam int WPL_W = $clog2(MAX_WIDTH / 8);

    rd_state_e          state;
    logic [WPL_W-1:0]   wpl;       // words per line of the accepted stripe
    logic [WPL_W-1:0]   bx;        // current block column
    logic [2:0]         row;       // current row inside the block
    logic [ADDR_W-1:0]  addr;      // row*wpl + bx, built by accumulation
    logic               inflight;  // a read was issued last cycle
    logic               tag_sob;
    logic               tag_eob;
    logic               tag_last;

    logic               accept;
    logic               issue;
    logic               pop;
    logic               last_read;
    logic [2:0]         credit;
    logic [1:0]         fifo_count;
    beat_t              push_beat;
    beat_t              head;

    // NOTE: every signal assigned here gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        pop       = blk_valid_o & blk_ready_i;
        accept    = ((state == S_IDLE) || (state == S_DONE)) && stripe_valid_i;
        last_read = (row == 3'd7) && (bx == wpl - WPL_W'(1));
        // Entries that will still be held after this cycle's pop, counting the
        // read whose data lands this cycle. Crediting the pop is what allows
        // one beat per cycle through a 2-entry FIFO with a 1-cycle RAM.
        credit    = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
        issue     = (state == S_READ) && (fifo_count != 2'd2) && (credit < 3'd2);
    end

    assign rd_en_o   = issue;
    assign rd_addr_o = addr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            wpl           <= '0;
            bx            <= '0;
            row           <= 3'd0;
            addr          <= '0;
            inflight      <= 1'b0;
            tag_sob       <= 1'b0;
            tag_eob       <= 1'b0;
            tag_last      <= 1'b0;
            stripe_done_o <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every
            // right-hand side sees the pre-edge values, as the flops do.
            inflight      <= issue;
            stripe_done_o <= 1'b0;
            if (issue) begin
                tag_sob  <= (row == 3'd0);
                tag_eob  <= (row == 3'd7);
                tag_last <= last_read;
            end

            if (accept) begin
                // DONE accepts as well, so a held stripe_valid_i restarts
                // without an IDLE bubble.
                wpl   <= WPL_W'(width_i >> 3);
                bx    <= '0;
                row   <= 3'd0;
                addr  <= '0;
                state <= S_READ;
            end else begin
                case (state)
                    S_IDLE: begin
                    end
                    S_READ: begin
                        if (issue) begin
                            if (row == 3'd7) begin
                                row  <= 3'd0;
                                bx   <= bx + WPL_W'(1);
                                addr <= ADDR_W'(bx) + ADDR_W'(1);
                                if (last_read) begin
                                    state <= S_DRAIN;
                                end
                            end else begin
                                row  <= row + 3'd1;
                                addr <= addr + ADDR_W'(wpl);
                            end
                        end
                    end
                    S_DRAIN: begin
                        if ((fifo_count == 2'd0) && !inflight) begin
                            state         <= S_DONE;
                            stripe_done_o <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Read data arrives one cycle after rd_en_o; its tags travel alongside.
    always_comb begin
        push_beat      = '0;
        push_beat.data = rd_data_i;
        push_beat.sob  = tag_sob;
        push_beat.eob  = tag_eob;
        push_beat.last = tag_last;
    end

    jenc_skid_fifo2 u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (inflight),
        .in_beat   (push_beat),
        .out_valid (blk_valid_o),
        .out_ready (blk_ready_i),
        .out_beat  (head),
        .count     (fifo_count)
    );

    assign blk_data_o = head.data;
    assign blk_sob_o  = head.sob;
    assign blk_eob_o  = head.eob;
    assign blk_last_o = head.last;

endmodule
